// File: rtl/seq_bin_to_bcd.sv
// seq_bin_to_bcd: multi-cycle double-dabble converter from an unsigned
// product magnitude to packed BCD, with a start/busy/done handshake.
module seq_bin_to_bcd #(
   parameter int BIN_W  = 15,
   parameter int DIGITS = 5
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   input  logic                  sign_in,
   output logic                  busy,
   output logic                  done,
   output logic [DIGITS*4-1:0]   bcd,
   output logic                  sign_out
);

   localparam int BCD_W = DIGITS * 4;
   localparam int CNT_W = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {
      IDLE = 2'b01,
      CONV = 2'b10
   } state_t;

   state_t             state;
   logic [BIN_W-1:0]   sh;
   logic [BCD_W-1:0]   scr;
   logic [CNT_W-1:0]   cnt;
   logic               sign_l;

   logic [BCD_W-1:0]       adj;
   logic [BCD_W+BIN_W-1:0] cat;
   logic [BCD_W-1:0]       scr_nxt;
   logic [BIN_W-1:0]       sh_nxt;

   // Add-3 correction on pre-shift digits, then one left shift of the pair.
   always_comb begin
      adj = scr;
      for (int d = 0; d < DIGITS; d++) begin
         if (scr[d*4 +: 4] >= 4'd5)
            adj[d*4 +: 4] = scr[d*4 +: 4] + 4'd3;
      end
      cat = {adj, sh} << 1;
      {scr_nxt, sh_nxt} = cat;
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge sys_clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sh       <= '0;
         scr      <= '0;
         cnt      <= '0;
         sign_l   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         sign_out <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sh     <= bin;
                  scr    <= '0;
                  cnt    <= CNT_W'(BIN_W);
                  sign_l <= sign_in;
                  busy   <= 1'b1;
                  state  <= CONV;
               end
            end
            CONV: begin
               sh  <= sh_nxt;
               scr <= scr_nxt;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  bcd      <= scr_nxt;
                  sign_out <= sign_l;
                  done     <= 1'b1;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// tb_seq_bin_to_bcd: directed checks of latency, handshake, reset
// and result values for the sequential BCD converter.
module tb_seq_bin_to_bcd;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [14:0] bin = '0;
   logic        sign_in = 1'b0;
   logic        busy;
   logic        done;
   logic [19:0] bcd;
   logic        sign_out;

   int checks = 0;
   int errors = 0;

   seq_bin_to_bcd #(.BIN_W(15), .DIGITS(5)) dut (
      .sys_clk  (sys_clk),
      .rst      (rst),
      .start    (start),
      .bin      (bin),
      .sign_in  (sign_in),
      .busy     (busy),
      .done     (done),
      .bcd      (bcd),
      .sign_out (sign_out)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [19:0] obs,
                      input logic [19:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One conversion; optionally pokes bin/start at iteration poke_at.
   task automatic conv(input string tag, input logic [14:0] b,
                       input logic s, input logic [19:0] eb,
                       input logic es, input int poke_at,
                       input logic [14:0] poke_bin,
                       input logic poke_start);
      bin = b;
      sign_in = s;
      start = 1'b1;
      step();
      start = 1'b0;
      chk({tag, "_busy_acc"}, 20'(busy), 20'd1);
      for (int i = 1; i <= 15; i++) begin
         if (i == poke_at) begin
            bin = poke_bin;
            sign_in = ~s;
            start = poke_start;
         end
         step();
         start = 1'b0;
         if (i < 15) begin
            if (busy !== 1'b1 || done !== 1'b0)
               chk({tag, "_mid"}, {18'd0, busy, done}, 20'b10);
         end
      end
      chk({tag, "_done"}, 20'(done), 20'd1);
      chk({tag, "_busy_end"}, 20'(busy), 20'd0);
      chk({tag, "_bcd"}, bcd, eb);
      chk({tag, "_sign"}, 20'(sign_out), 20'(es));
      step();
      chk({tag, "_done_1cyc"}, 20'(done), 20'd0);
   endtask

   int dn;

   initial begin
      #1 rst = 1'b0;
      #2;
      chk("rst_busy", 20'(busy), 20'd0);
      chk("rst_done", 20'(done), 20'd0);
      chk("rst_bcd", bcd, 20'h00000);
      chk("rst_sign", 20'(sign_out), 20'd0);
      start = 1'b1;
      step();
      step();
      chk("rst_hold_busy", 20'(busy), 20'd0);
      start = 1'b0;
      #2 rst = 1'b1;
      step();

      conv("zero", 15'd0, 1'b0, 20'h00000, 1'b0, 0, 15'd0, 1'b0);
      conv("max", 15'd32767, 1'b0, 20'h32767, 1'b0, 0, 15'd0, 1'b0);
      conv("b16384", 15'd16384, 1'b1, 20'h16384, 1'b1, 3, 15'd5, 1'b0);
      conv("zneg", 15'd0, 1'b1, 20'h00000, 1'b1, 0, 15'd0, 1'b0);
      conv("ign", 15'd9, 1'b1, 20'h00009, 1'b1, 5, 15'd1234, 1'b1);
      dn = 0;
      for (int i = 0; i < 18; i++) begin
         step();
         if (done === 1'b1) dn++;
      end
      chk("ign_no_2nd_done", 20'(dn), 20'd0);
      chk("ign_bcd_hold", bcd, 20'h00009);

      // Reset in the middle of a conversion.
      bin = 15'd12345;
      sign_in = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 7; i++) step();
      #2 rst = 1'b0;
      #1;
      chk("arst_busy", 20'(busy), 20'd0);
      chk("arst_done", 20'(done), 20'd0);
      chk("arst_bcd", bcd, 20'h00000);
      chk("arst_sign", 20'(sign_out), 20'd0);
      step();
      #2 rst = 1'b1;
      dn = 0;
      for (int i = 0; i < 18; i++) begin
         step();
         if (done === 1'b1) dn++;
      end
      chk("arst_no_done", 20'(dn), 20'd0);
      conv("ten", 15'd10, 1'b0, 20'h00010, 1'b0, 0, 15'd0, 1'b0);

      // Back-to-back with start held high.
      bin = 15'd99;
      sign_in = 1'b0;
      start = 1'b1;
      step();
      for (int i = 1; i <= 15; i++) begin
         step();
         if (i < 15 && done !== 1'b0)
            chk("b2b_a_early", 20'(done), 20'd0);
      end
      chk("b2b_a_done", 20'(done), 20'd1);
      chk("b2b_a_bcd", bcd, 20'h00099);
      bin = 15'd100;
      step();
      chk("b2b_reaccept", 20'(busy), 20'd1);
      chk("b2b_gap_done", 20'(done), 20'd0);
      for (int i = 1; i <= 15; i++) begin
         step();
         if (i < 15 && done !== 1'b0)
            chk("b2b_b_early", 20'(done), 20'd0);
      end
      start = 1'b0;
      chk("b2b_b_done", 20'(done), 20'd1);
      chk("b2b_b_bcd", bcd, 20'h00100);
      step();
      chk("b2b_b_1cyc", 20'(done), 20'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
